display_packet_sequencer: RTL and testbench

- Sits between the UART byte receiver and the two 7-segment decoders in the speed display CPLD.
- Assembles the 3-byte speed packet (ASCII tens digit, ASCII units digit, 0x00 terminator) into BCD digits and commits them atomically to the display.
- Handles malformed packets, inter-byte timeouts and resynchronisation after errors.
- Blanks the display when updates go stale.

---
 rtl/display_packet_sequencer.sv | 133 +++++++++++++
 tb/tb_display_packet_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_packet_sequencer.sv
// Turns the 3-byte UART speed packet (tens, units, 0x00) into BCD digits and commits them atomically.
// Also handles malformed packets, inter-byte timeouts, resync after errors, and stale-display blanking.
module display_packet_sequencer #(
  parameter int unsigned GAP_MAX   = 4096,
  parameter int unsigned STALE_MAX = 1843200,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic       clk1M8,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_perr,
  output logic [3:0] digit_l,
  output logic [3:0] digit_r,
  output logic       blank_l,
  output logic       blank_r,
  output logic       disp_load,
  output logic       pkt_err,
  output logic [7:0] err_count
);

  localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam int SW = $clog2(STALE_MAX + 1);

  typedef enum logic [1:0] {S_TENS, S_UNITS, S_TERM, S_RESYNC} state_t;

  state_t        state_q;
  logic [3:0]    tens_q, units_q;
  logic [3:0]    digit_l_q, digit_r_q;
  logic          blank_l_q, blank_r_q;
  logic          disp_load_q, pkt_err_q;
  logic [7:0]    err_count_q;
  logic [GW-1:0] gap_q;
  logic [SW-1:0] stale_q;

  logic is_digit, is_term, in_pkt, gap_to, commit_d, err_d;

  assign is_digit = !rx_perr && (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = !rx_perr && (rx_data == 8'h00);
  assign in_pkt   = (state_q == S_UNITS) || (state_q == S_TERM);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign gap_to   = in_pkt && !rx_valid && (gap_q == GW'(GAP_MAX - 1));

  always_comb begin
    commit_d = rx_valid && (state_q == S_TERM) && is_term;
    err_d    = gap_to;
    if (rx_valid) begin
      case (state_q)
        S_TENS:  err_d = !is_digit && !is_term;
        S_UNITS: err_d = !is_digit;
        S_TERM:  err_d = !is_term;
        default: err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk1M8) begin
    if (rst) begin
      state_q     <= S_TENS;
      tens_q      <= '0;
      units_q     <= '0;
      digit_l_q   <= '0;
      digit_r_q   <= '0;
      blank_l_q   <= 1'b1;
      blank_r_q   <= 1'b1;
      disp_load_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_count_q <= '0;
      gap_q       <= '0;
      stale_q     <= '0;
    end else begin
      disp_load_q <= commit_d;
      pkt_err_q   <= err_d;
      if (err_d && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;

      if (rx_valid || !in_pkt || gap_to) gap_q <= '0;
      else                               gap_q <= gap_q + GW'(1);

      if (rx_valid) begin
        case (state_q)
          S_TENS: begin
            if (is_digit) begin
              tens_q  <= rx_data[3:0];
              state_q <= S_UNITS;
            end else if (!is_term) begin
              state_q <= S_RESYNC;
            end
          end
          S_UNITS: begin
            if (is_digit) begin
              units_q <= rx_data[3:0];
              state_q <= S_TERM;
            end else if (is_term) begin
              state_q <= S_TENS;
            end else begin
              state_q <= S_RESYNC;
            end
          end
          S_TERM:  state_q <= is_term ? S_TENS : S_RESYNC;
          default: if (is_term) state_q <= S_TENS;
        endcase
      end else if (gap_to) begin
        state_q <= S_TENS;
        tens_q  <= '0;
        units_q <= '0;
      end

      // Display only ever changes from the holding registers on a full commit.
      if (commit_d) begin
        digit_l_q <= tens_q;
        digit_r_q <= units_q;
        blank_r_q <= 1'b0;
        blank_l_q <= LZ_BLANK && (tens_q == 4'd0);
        stale_q   <= '0;
      end else if (stale_q != SW'(STALE_MAX)) begin
        stale_q <= stale_q + SW'(1);
        if (stale_q == SW'(STALE_MAX - 1)) begin
          blank_l_q <= 1'b1;
          blank_r_q <= 1'b1;
        end
      end
    end
  end

  assign digit_l   = digit_l_q;
  assign digit_r   = digit_r_q;
  assign blank_l   = blank_l_q;
  assign blank_r   = blank_r_q;
  assign disp_load = disp_load_q;
  assign pkt_err   = pkt_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_display_packet_sequencer.sv
// Scoreboarded random bench for the speed-display packet sequencer (two instances: leading-zero blanking on/off).
module tb_display_packet_sequencer;
  localparam int GAP   = 64;
  localparam int STALE = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_perr;

  logic [3:0] dl0, dr0, dl1, dr1;
  logic       bl0, br0, ld0, pe0, bl1, br1, ld1, pe1;
  logic [7:0] ec0, ec1;

  always #5 clk = ~clk;

  display_packet_sequencer #(.GAP_MAX(GAP), .STALE_MAX(STALE), .LZ_BLANK(1'b1)) dut_lz (
    .clk1M8(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .digit_l(dl0), .digit_r(dr0), .blank_l(bl0), .blank_r(br0),
    .disp_load(ld0), .pkt_err(pe0), .err_count(ec0));

  display_packet_sequencer #(.GAP_MAX(GAP), .STALE_MAX(STALE), .LZ_BLANK(1'b0)) dut_nolz (
    .clk1M8(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .digit_l(dl1), .digit_r(dr1), .blank_l(bl1), .blank_r(br1),
    .disp_load(ld1), .pkt_err(pe1), .err_count(ec1));

  typedef struct {
    bit is_commit;
    int dl, dr;
    bit bl_lz, bl_nolz;
    int ec;
  } ev_t;

  ev_t evq[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  checking = 1'b0;

  // Reference model: partial packet held as a list of digits plus a resync flag.
  int pend[$];
  bit resync;
  int idle, since_commit, m_dl, m_dr, m_err;
  bit c_bl_lz, c_bl_nolz, c_br;
  bit e_ld, e_pe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    pend.delete();
    resync = 0; idle = 0; since_commit = 0;
    m_dl = 0; m_dr = 0; m_err = 0;
    c_bl_lz = 1; c_bl_nolz = 1; c_br = 1;
    e_ld = 0; e_pe = 0;
    evq.delete();
  endfunction

  function automatic void model_err();
    ev_t ev;
    if (m_err < 255) m_err++;
    e_pe = 1;
    ev = '{is_commit: 1'b0, dl: m_dl, dr: m_dr, bl_lz: 1'b0, bl_nolz: 1'b0, ec: m_err};
    evq.push_back(ev);
  endfunction

  function automatic void model_commit();
    ev_t ev;
    m_dl = pend[0];
    m_dr = pend[1];
    pend.delete();
    c_bl_lz = (m_dl == 0);
    c_bl_nolz = 0;
    c_br = 0;
    since_commit = 0;
    e_ld = 1;
    ev = '{is_commit: 1'b1, dl: m_dl, dr: m_dr, bl_lz: c_bl_lz, bl_nolz: 1'b0, ec: m_err};
    evq.push_back(ev);
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d, input bit p);
    bit digit, term;
    e_ld = 0; e_pe = 0;
    since_commit++;
    if (v) begin
      idle = 0;
      digit = !p && d >= 8'h30 && d <= 8'h39;
      term  = !p && d == 8'h00;
      if (resync) begin
        if (term) resync = 0;
      end else if (term) begin
        if (pend.size() == 2) model_commit();
        else if (pend.size() == 1) begin model_err(); pend.delete(); end
      end else if (digit && pend.size() < 2) begin
        pend.push_back(int'(d[3:0]));
      end else begin
        model_err(); pend.delete(); resync = 1;
      end
    end else if (pend.size() > 0) begin
      idle++;
      if (idle == GAP) begin model_err(); pend.delete(); idle = 0; end
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit p);
    rx_valid = v; rx_data = d; rx_perr = p;
    @(posedge clk);
    model_edge(v, d, p);
    #1;
    rx_valid = 0; rx_data = 8'hxx; rx_perr = 0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    rst = 1; rx_valid = 0; rx_perr = 0; rx_data = 8'h00;
    @(posedge clk);
    model_reset();
    checking = 1;
    #1;
    rst = 0;
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b);
    step(1, a, 0); step(1, b, 0); step(1, 8'h00, 0);
    idle_n(2);
  endtask

  // Monitor: continuous display state plus event scoreboard on every pulse.
  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("digit_l", dl0, m_dl);
      chk("digit_r", dr0, m_dr);
      chk("blank_l_lz", bl0, (since_commit >= STALE) ? 1 : c_bl_lz);
      chk("blank_l_nolz", bl1, (since_commit >= STALE) ? 1 : c_bl_nolz);
      chk("blank_r", br0, (since_commit >= STALE) ? 1 : c_br);
      chk("disp_load", ld0, e_ld);
      chk("pkt_err", pe0, e_pe);
      chk("err_count", ec0, m_err);
      if (ld0 || pe0 || ld1 || pe1) begin
        if (evq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_pulse: load=%0b err=%0b with empty scoreboard", ld0, pe0);
        end else begin
          ev_t ev;
          ev = evq.pop_front();
          chk("ev_load", ld0, ev.is_commit);
          chk("ev_err", pe0, !ev.is_commit);
          chk("ev_load_nolz", ld1, ev.is_commit);
          chk("ev_err_nolz", pe1, !ev.is_commit);
          chk("ev_err_count", ec0, ev.ec);
          chk("ev_err_count_nolz", ec1, ev.ec);
          if (ev.is_commit) begin
            chk("ev_digit_l", dl0, ev.dl);
            chk("ev_digit_r", dr0, ev.dr);
            chk("ev_digit_l_nolz", dl1, ev.dl);
            chk("ev_digit_r_nolz", dr1, ev.dr);
            chk("ev_blank_l_lz", bl0, ev.bl_lz);
            chk("ev_blank_l_nolz", bl1, ev.bl_nolz);
            chk("ev_blank_r_nolz", br1, 0);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int gap;
    do_reset();
    idle_n(3);
    pkt(8'h34, 8'h37);
    pkt(8'h30, 8'h35);

    pkt(8'h34, 8'h37);
    step(1, 8'h31, 1); step(1, 8'h32, 0); step(1, 8'h00, 0);
    idle_n(2);
    pkt(8'h39, 8'h39);

    step(1, 8'h35, 0); idle_n(GAP); step(1, 8'h36, 0); step(1, 8'h00, 0);
    idle_n(2);
    step(1, 8'h35, 0); idle_n(GAP - 1); step(1, 8'h36, 0); step(1, 8'h00, 0);
    idle_n(2);

    pkt(8'h31, 8'h32);
    idle_n(STALE + 5);
    pkt(8'h33, 8'h34);

    step(1, 8'h35, 0); step(1, 8'h36, 0);
    do_reset();
    step(1, 8'h00, 0);
    idle_n(3);

    for (int i = 0; i < 260; i++) begin
      step(1, 8'h41, 0); step(1, 8'h00, 0);
    end
    pkt(8'h32, 8'h38);

    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 3; k++) begin
          b = (k == 2) ? 8'h00 : 8'(8'h30 + $urandom_range(0, 9));
          case ($urandom_range(0, 11))
            0: step(1, b, 1);
            1: step(1, 8'($urandom_range(0, 255)), 0);
            default: step(1, b, 0);
          endcase
          gap = ($urandom_range(0, 15) == 0) ? $urandom_range(GAP - 4, GAP + 4) : $urandom_range(0, 2);
          idle_n(gap);
        end
      end else begin
        step(1, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        idle_n($urandom_range(0, 3));
      end
    end
    idle_n(4);
    chk("scoreboard_drained", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
